rat_uart_tx: RTL and testbench

RAT_UART_TX -- requirements
Module: rat_uart_tx

---
 rtl/rat_io_pkg.sv | 27 ++
 rtl/rat_uart_tx_if.sv | 13 +
 rtl/rat_fifo.sv | 51 +++++
 rtl/rat_uart_tx.sv | 141 ++++++++++++++
 tb/tb_rat_uart_tx.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/rat_io_pkg.sv
// Shared types and constants for the MCU-attached UART transmitter:
// FSM state encoding, STATUS bit positions and default port addresses.
package rat_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_CNT   = 4;

    localparam logic [7:0] DEF_DATA_ID = 8'h40;
    localparam logic [7:0] DEF_CTRL_ID = 8'h41;
    localparam logic [7:0] STATUS_RST  = 8'h04;

    // STATUS only has a 4-bit count field, so a 16-deep FIFO reads back 15 when full.
    function automatic logic [3:0] sat_count(input logic [4:0] c);
        return (c > 5'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/rat_uart_tx_if.sv
// MCU I/O port bundle seen by the UART: strobed port writes in, serial line,
// status byte and interrupt out.
interface rat_uart_tx_if;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic       TX;
    logic [7:0] STATUS;
    logic       INT;

    modport master (output PORT_ID, OUT_PORT, IO_STRB, input TX, STATUS, INT);
    modport slave  (input PORT_ID, OUT_PORT, IO_STRB, output TX, STATUS, INT);
endinterface

// File: rtl/rat_fifo.sv
// Small synchronous FIFO with occupancy count and flush.
// Latency: written entry visible on rd_dat the cycle after push; rd_dat is combinational from head.
// Backpressure: push ignored when full unless a pop happens the same cycle; flush wins over push.
module rat_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_dat,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/rat_uart_tx.sv
// UART transmitter on the MCU port bus, 8N1 framing from a small FIFO; INT only with RAT_UART_TX_INT_EN.
// Latency: TX falls two edges after a write lands in an empty FIFO while idle; TX/STATUS/INT registered.
// Backpressure: none toward the MCU; writes to a full FIFO are dropped and flagged in sticky OVF.
module rat_uart_tx
    import rat_io_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         DEPTH        = 4,
    parameter logic [7:0] DATA_ID      = DEF_DATA_ID,
    parameter logic [7:0] CTRL_ID      = DEF_CTRL_ID
) (
    input  logic          CLK,
    input  logic          RESET,
    rat_uart_tx_if.slave  bus
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    tx_state_t         state;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic              tx_q;
    logic [7:0]        status_q;
    logic [7:0]        status_nxt;
    logic              ovf;

    logic              data_wr;
    logic              ctrl_wr;
    logic              pop;
    logic              flush;
    logic              baud_end;
    logic [7:0]        rd_dat;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;

    assign data_wr  = bus.IO_STRB && (bus.PORT_ID == DATA_ID);
    assign ctrl_wr  = bus.IO_STRB && (bus.PORT_ID == CTRL_ID);
    assign flush    = ctrl_wr && bus.OUT_PORT[1];
    assign pop      = (state == IDLE) && !fifo_empty;
    assign baud_end = (baud == BAUD_W'(CLKS_PER_BIT - 1));

    rat_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk    (CLK),
        .rst    (RESET),
        .push   (data_wr),
        .pop    (pop),
        .flush  (flush),
        .wr_dat (bus.OUT_PORT),
        .rd_dat (rd_dat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_cnt)
    );

    always_comb begin
        status_nxt                          = '0;
        status_nxt[STAT_BUSY]               = (state != IDLE);
        status_nxt[STAT_FULL]               = fifo_full;
        status_nxt[STAT_EMPTY]              = fifo_empty;
        status_nxt[STAT_OVF]                = ovf;
        status_nxt[STAT_CNT+3:STAT_CNT]     = sat_count(5'(fifo_cnt));
    end

`ifdef RAT_UART_TX_INT_EN
    logic int_q;
    assign bus.INT = int_q;
`else
    assign bus.INT = 1'b0;
`endif

    // TX is derived from the state before the edge, so the line trails the FSM by one cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
            ovf      <= 1'b0;
            status_q <= STATUS_RST;
`ifdef RAT_UART_TX_INT_EN
            int_q    <= 1'b0;
`endif
        end else begin
            status_q <= status_nxt;
            if (data_wr && fifo_full && !pop) begin
                ovf <= 1'b1;
            end else if (ctrl_wr && bus.OUT_PORT[0]) begin
                ovf <= 1'b0;
            end
`ifdef RAT_UART_TX_INT_EN
            int_q <= (state == STOP) && baud_end && fifo_empty;
`endif
            case (state)
                IDLE: begin
                    tx_q    <= 1'b1;
                    baud    <= '0;
                    bit_idx <= '0;
                    if (!fifo_empty) begin
                        shreg <= rd_dat;
                        state <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (baud_end) begin
                        baud  <= '0;
                        state <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    tx_q <= shreg[bit_idx];
                    if (baud_end) begin
                        baud    <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (baud_end) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.TX     = tx_q;
    assign bus.STATUS = status_q;
endmodule

// File: tb/tb_rat_uart_tx.sv
// Bench for rat_uart_tx: directed scenarios plus random port traffic, every cycle
// compared against a frame-level model of the serial line, FIFO queue and flags.
module tb_rat_uart_tx;
    localparam int         CPB     = 4;
    localparam int         DEPTH   = 4;
    localparam int         FRAME   = 10 * CPB;
    localparam logic [7:0] DATA_ID = 8'h40;
    localparam logic [7:0] CTRL_ID = 8'h41;
`ifdef RAT_UART_TX_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rat_uart_tx_if bus ();

    rat_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .DATA_ID(DATA_ID), .CTRL_ID(CTRL_ID)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: bytes waiting, sticky overflow, and position inside the frame on the wire.
    logic [7:0] m_q [$];
    logic       m_ovf    = 1'b0;
    logic       m_active = 1'b0;
    int         m_fcyc   = 0;
    logic [7:0] m_byte   = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        return fr[idx];
    endfunction

    task automatic tick(input logic r, input logic s, input logic [7:0] id, input logic [7:0] d);
        logic       e_tx;
        logic [7:0] e_st;
        logic       e_int;
        int         n;
        rst          = r;
        bus.IO_STRB  = s;
        bus.PORT_ID  = id;
        bus.OUT_PORT = d;
        if (r) begin
            e_tx  = 1'b1;
            e_st  = 8'h04;
            e_int = 1'b0;
            m_q.delete();
            m_ovf    = 1'b0;
            m_active = 1'b0;
            m_fcyc   = 0;
        end else begin
            n        = m_q.size();
            e_tx     = m_active ? frame_bit(m_byte, m_fcyc / CPB) : 1'b1;
            e_st     = '0;
            e_st[0]  = m_active;
            e_st[1]  = (n == DEPTH);
            e_st[2]  = (n == 0);
            e_st[3]  = m_ovf;
            e_st[7:4] = 4'((n > 15) ? 15 : n);
            e_int    = INT_EN && m_active && (m_fcyc == FRAME - 1) && (n == 0);
            if (m_active) begin
                m_fcyc++;
                if (m_fcyc == FRAME) m_active = 1'b0;
            end else if (n > 0) begin
                m_byte   = m_q.pop_front();
                m_active = 1'b1;
                m_fcyc   = 0;
            end
            if (s && id == DATA_ID) begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else m_ovf = 1'b1;
            end
            if (s && id == CTRL_ID) begin
                if (d[0]) m_ovf = 1'b0;
                if (d[1]) m_q.delete();
            end
        end
        @(posedge clk);
        #1;
        chk("tx", 32'(bus.TX), 32'(e_tx));
        chk("status", 32'(bus.STATUS), 32'(e_st));
        chk("int", 32'(bus.INT), 32'(e_int));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        tick(1'b0, 1'b1, id, d);
    endtask

    initial begin
        int guard;
        logic [7:0] pid;
        logic [7:0] dat;

        bus.IO_STRB  = 1'b0;
        bus.PORT_ID  = 8'h00;
        bus.OUT_PORT = 8'h00;
        tick(1'b1, 1'b0, 8'h00, 8'h00);
        tick(1'b1, 1'b1, DATA_ID, 8'hFF);
        idle(2);

        // Single frame, then busy/idle status.
        wr(DATA_ID, 8'hA5);
        idle(FRAME + 4);

        // Overflow during a frame, cleared by control write.
        wr(DATA_ID, 8'h01);
        idle(2);
        for (int i = 0; i < 5; i++) wr(DATA_ID, 8'h10 + 8'(i));
        idle(3);
        wr(8'h42, 8'h03);
        wr(CTRL_ID, 8'h01);
        idle(5 * (FRAME + 1) + 4);

        // Two back-to-back frames.
        wr(DATA_ID, 8'h11);
        wr(DATA_ID, 8'h22);
        idle(2 * (FRAME + 1) + 4);

        // Reset during data bit 3 aborts and discards the queued byte.
        wr(DATA_ID, 8'h3C);
        wr(DATA_ID, 8'h5A);
        guard = 0;
        while (!(m_active && m_fcyc == 4 * CPB + 1) && guard < 200) begin
            idle(1);
            guard++;
        end
        chk("wait_bit3", 32'(guard < 200), 32'd1);
        tick(1'b1, 1'b0, 8'h00, 8'h00);
        idle(FRAME + 4);

        // Full FIFO with a write landing on the pop cycle.
        for (int i = 0; i < 5; i++) wr(DATA_ID, 8'hC0 + 8'(i));
        guard = 0;
        while (!(!m_active && m_q.size() == DEPTH) && guard < 200) begin
            idle(1);
            guard++;
        end
        chk("wait_full_pop", 32'(guard < 200), 32'd1);
        wr(DATA_ID, 8'h77);
        idle(2);
        wr(CTRL_ID, 8'h02);
        idle(FRAME + 4);

        // Random port traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                tick(1'b1, 1'b0, 8'h00, 8'h00);
            end else if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: pid = DATA_ID;
                    6, 7:             pid = CTRL_ID;
                    default:          pid = 8'h80 | 8'($urandom_range(0, 127));
                endcase
                dat = 8'($urandom);
                if (pid == CTRL_ID) dat[1] = ($urandom_range(0, 3) == 0);
                wr(pid, dat);
            end else begin
                idle(1);
            end
        end
        idle(5 * (FRAME + 1) + 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
